// File: rtl/traffic_pkg.sv
// Shared types, widths and defaults for the intersection loop-sensor front-end.
package traffic_pkg;

    localparam int WAIT_W = 8;
    localparam int DCNT_W = 4;

    localparam int DEF_DEBOUNCE_CYCLES  = 4;
    localparam int DEF_STARVE_THRESHOLD = 200;

    typedef logic [WAIT_W-1:0] wait_t;

    localparam wait_t WAIT_MAX = '1;

    // Request latch per direction. SERVED marks "green is being shown";
    // it exists so a vehicle sitting on the loop during green does not re-call.
    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_PENDING = 2'd1,
        REQ_SERVED  = 2'd2
    } req_state_t;

    // Green clears unconditionally; otherwise a filtered vehicle sets the
    // call, and a pending call is held even after the vehicle leaves.
    function automatic req_state_t req_step(input req_state_t cur,
                                            input logic       filt,
                                            input logic       green);
        if (green)
            return REQ_SERVED;
        else if (filt)
            return REQ_PENDING;
        else if (cur == REQ_PENDING)
            return REQ_PENDING;
        else
            return REQ_IDLE;
    endfunction

    // Wait count follows the registered call, so it reads 1 one edge after
    // the call appears; green zeroes it on the same edge that drops the call.
    function automatic wait_t wait_step(input logic  pending,
                                        input logic  green,
                                        input wait_t cur);
        if (!pending || green)
            return '0;
        else if (cur == WAIT_MAX)
            return cur;
        else
            return cur + wait_t'(1);
    endfunction

endpackage

// File: rtl/sensor_filter.sv
// Two-flop synchronizer followed by a debounce filter for one loop sensor.
module sensor_filter
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic              s1;
    logic              s2;
    logic [DCNT_W-1:0] dcnt;

    // Bring the asynchronous loop input into the clock domain.
    // NOTE: non-blocking assignments make s2 take the old s1, forming a real
    // two-stage chain; blocking here would collapse it into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Change the filtered level only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b0;
            dcnt <= '0;
        end else if (s2 == filt) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            filt <= s2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DCNT_W'(1);
        end
    end

endmodule

// File: rtl/vehicle_detect_conditioner.sv
// Conditions NS/EW loop sensors into latched service requests for the
// intersection controller, with per-direction wait counters and starvation flags.
module vehicle_detect_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int STARVE_THRESHOLD = DEF_STARVE_THRESHOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ns_sensor_raw,
    input  logic              ew_sensor_raw,
    input  logic              ns_green,
    input  logic              ew_green,
    output logic              NS_VEHICLE_DETECT,
    output logic              EW_VEHICLE_DETECT,
    output logic [WAIT_W-1:0] ns_wait,
    output logic [WAIT_W-1:0] ew_wait,
    output logic              ns_starved,
    output logic              ew_starved
);

    localparam wait_t STARVE_LIM = wait_t'(STARVE_THRESHOLD);

    logic       ns_filt;
    logic       ew_filt;
    req_state_t ns_state;
    req_state_t ns_state_nxt;
    req_state_t ew_state;
    req_state_t ew_state_nxt;
    wait_t      ns_wait_nxt;
    wait_t      ew_wait_nxt;

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ns_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ns_sensor_raw),
        .filt (ns_filt)
    );

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ew_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ew_sensor_raw),
        .filt (ew_filt)
    );

    // Request latches and wait counters for both directions.
    always_ff @(posedge clk) begin
        if (rst) begin
            ns_state <= REQ_IDLE;
            ew_state <= REQ_IDLE;
            ns_wait  <= '0;
            ew_wait  <= '0;
        end else begin
            ns_state <= ns_state_nxt;
            ew_state <= ew_state_nxt;
            ns_wait  <= ns_wait_nxt;
            ew_wait  <= ew_wait_nxt;
        end
    end

    // Next request state and wait count; the two directions never interact.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        ns_state_nxt = ns_state;
        ew_state_nxt = ew_state;
        ns_wait_nxt  = ns_wait;
        ew_wait_nxt  = ew_wait;

        ns_state_nxt = req_step(ns_state, ns_filt, ns_green);
        ew_state_nxt = req_step(ew_state, ew_filt, ew_green);
        ns_wait_nxt  = wait_step(ns_state == REQ_PENDING, ns_green, ns_wait);
        ew_wait_nxt  = wait_step(ew_state == REQ_PENDING, ew_green, ew_wait);
    end

    assign NS_VEHICLE_DETECT = (ns_state == REQ_PENDING);
    assign EW_VEHICLE_DETECT = (ew_state == REQ_PENDING);

    assign ns_starved = (ns_wait >= STARVE_LIM);
    assign ew_starved = (ew_wait >= STARVE_LIM);

endmodule

// File: tb/tb_vehicle_detect_conditioner.sv
// Scoreboard bench: stimulus pushes hand-computed expectations for each
// clock edge, a monitor pops one per cycle on the falling edge and compares.
module tb_vehicle_detect_conditioner;
    import traffic_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  ns_sensor_raw;
    logic  ew_sensor_raw;
    logic  ns_green;
    logic  ew_green;
    logic  ns_det;
    logic  ew_det;
    wait_t ns_wait;
    wait_t ew_wait;
    logic  ns_starved;
    logic  ew_starved;

    int checks = 0;
    int errors = 0;

    // mask bits: 0 ns_det, 1 ew_det, 2 ns_wait, 3 ew_wait, 4 ns_starved, 5 ew_starved
    localparam bit [5:0] M_ALL = 6'b111111;

    typedef struct {
        string    name;
        bit [5:0] mask;
        logic     nd;
        logic     ed;
        wait_t    nw;
        wait_t    ew;
        logic     nst;
        logic     est;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    vehicle_detect_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .STARVE_THRESHOLD (200)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ns_sensor_raw     (ns_sensor_raw),
        .ew_sensor_raw     (ew_sensor_raw),
        .ns_green          (ns_green),
        .ew_green          (ew_green),
        .NS_VEHICLE_DETECT (ns_det),
        .EW_VEHICLE_DETECT (ew_det),
        .ns_wait           (ns_wait),
        .ew_wait           (ew_wait),
        .ns_starved        (ns_starved),
        .ew_starved        (ew_starved)
    );

    task automatic check(input string name, input string field,
                         input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d at %0t", name, field, act, req, $time);
        end
    endtask

    // Advance one rising edge with the inputs already applied and queue the
    // outputs expected right after that edge.
    task automatic tick(input string name, input bit [5:0] mask,
                        input logic nd, input logic ed,
                        input int nw, input int ew,
                        input logic nst, input logic est);
        exp_t e;
        @(posedge clk);
        e.name = name;
        e.mask = mask;
        e.nd   = nd;
        e.ed   = ed;
        e.nw   = wait_t'(nw);
        e.ew   = wait_t'(ew);
        e.nst  = nst;
        e.est  = est;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mask[0]) check(e.name, "ns_det",     8'(ns_det),     8'(e.nd));
                if (e.mask[1]) check(e.name, "ew_det",     8'(ew_det),     8'(e.ed));
                if (e.mask[2]) check(e.name, "ns_wait",    ns_wait,        e.nw);
                if (e.mask[3]) check(e.name, "ew_wait",    ew_wait,        e.ew);
                if (e.mask[4]) check(e.name, "ns_starved", 8'(ns_starved), 8'(e.nst));
                if (e.mask[5]) check(e.name, "ew_starved", 8'(ew_starved), 8'(e.est));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        // Reset held two cycles with both sensors active.
        rst = 1'b1; ns_sensor_raw = 1'b1; ew_sensor_raw = 1'b1;
        ns_green = 1'b0; ew_green = 1'b0;
        tick("rst_e0", M_ALL, 0, 0, 0, 0, 0, 0);
        tick("rst_e1", M_ALL, 0, 0, 0, 0, 0, 0);

        // Rise latency: DETECT after edge 6, wait counts from the next edge.
        rst = 1'b0;
        for (int e = 0; e <= 5; e++) tick("rise_pre", M_ALL, 0, 0, 0, 0, 0, 0);
        tick("rise_e6", M_ALL, 1, 1, 0, 0, 0, 0);
        tick("rise_e7", M_ALL, 1, 1, 1, 1, 0, 0);
        tick("rise_e8", M_ALL, 1, 1, 2, 2, 0, 0);

        // Reset mid-operation drops both calls.
        rst = 1'b1;
        tick("midop_rst", M_ALL, 0, 0, 0, 0, 0, 0);
        ns_sensor_raw = 1'b0; ew_sensor_raw = 1'b0;
        tick("midop_rst2", M_ALL, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Glitch rejection: 3 cycles high never reaches the filter output.
        ns_sensor_raw = 1'b1;
        for (int e = 0; e <= 2; e++) tick("glitch3_hi", M_ALL, 0, 0, 0, 0, 0, 0);
        ns_sensor_raw = 1'b0;
        for (int e = 3; e <= 10; e++) tick("glitch3_lo", M_ALL, 0, 0, 0, 0, 0, 0);

        // 4 cycles high is accepted; the call is then held after departure.
        ns_sensor_raw = 1'b1;
        for (int e = 0; e <= 3; e++) tick("pulse4_hi", M_ALL, 0, 0, 0, 0, 0, 0);
        ns_sensor_raw = 1'b0;
        tick("pulse4_e4", M_ALL, 0, 0, 0, 0, 0, 0);
        tick("pulse4_e5", M_ALL, 0, 0, 0, 0, 0, 0);
        tick("pulse4_e6", M_ALL, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) tick("hold", M_ALL, 1, 0, k, 0, 0, 0);
        ns_green = 1'b1;
        tick("hold_green", M_ALL, 0, 0, 0, 0, 0, 0);
        ns_green = 1'b0;
        tick("hold_after1", M_ALL, 0, 0, 0, 0, 0, 0);
        tick("hold_after2", M_ALL, 0, 0, 0, 0, 0, 0);

        // Re-request after a 5-cycle EW green with the vehicle still present.
        rst = 1'b1; ew_sensor_raw = 1'b1;
        tick("rst2", M_ALL, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int e = 0; e <= 5; e++) tick("ew_pre", M_ALL, 0, 0, 0, 0, 0, 0);
        tick("ew_e6", M_ALL, 0, 1, 0, 0, 0, 0);
        tick("ew_e7", M_ALL, 0, 1, 0, 1, 0, 0);
        tick("ew_e8", M_ALL, 0, 1, 0, 2, 0, 0);
        ew_green = 1'b1;
        for (int g = 0; g < 5; g++) tick("ew_green", M_ALL, 0, 0, 0, 0, 0, 0);
        ew_green = 1'b0;
        tick("ew_rereq", M_ALL, 0, 1, 0, 0, 0, 0);

        // Saturation and starvation over 300 held cycles.
        for (int k = 1; k <= 300; k++)
            tick("ew_sat", M_ALL, 0, 1, 0, (k > 255) ? 255 : k, 0, (k >= 200) ? 1'b1 : 1'b0);
        ew_green = 1'b1;
        tick("ew_sat_clear", M_ALL, 0, 0, 0, 0, 0, 0);
        ew_green = 1'b0;

        // Independence: NS arrives at edge 0, EW at edge 3; both greens together.
        rst = 1'b1; ns_sensor_raw = 1'b0; ew_sensor_raw = 1'b0;
        tick("rst3", M_ALL, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        ns_sensor_raw = 1'b1;
        for (int e = 0; e <= 2; e++) tick("ind_pre", M_ALL, 0, 0, 0, 0, 0, 0);
        ew_sensor_raw = 1'b1;
        for (int e = 3; e <= 5; e++) tick("ind_pre", M_ALL, 0, 0, 0, 0, 0, 0);
        tick("ind_e6", M_ALL, 1, 0, 0, 0, 0, 0);
        for (int e = 7; e <= 19; e++)
            tick("ind_run", M_ALL, 1, (e >= 9) ? 1'b1 : 1'b0, e - 6, (e >= 9) ? e - 9 : 0, 0, 0);
        ns_green = 1'b1; ew_green = 1'b1;
        tick("ind_both_green", M_ALL, 0, 0, 0, 0, 0, 0);
        ns_green = 1'b0; ew_green = 1'b0;
        tick("ind_e21", M_ALL, 1, 1, 0, 0, 0, 0);
        tick("ind_e22", M_ALL, 1, 1, 1, 1, 0, 0);
        ns_green = 1'b1;
        tick("ind_ns_green", M_ALL, 0, 1, 0, 2, 0, 0);
        ns_green = 1'b0;
        tick("ind_e24", M_ALL, 1, 1, 0, 3, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        check("drain", "queue", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
